// File: rtl/isp_awb_gain_m_pkg.sv
// Shared types and default parameters for the gray-world AWB gain stage.
// The FSM state encoding is exported so the top can expose it for observation.
package isp_awb_gain_m_pkg;

    localparam int DEF_BITS    = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_GAIN_W  = 10;
    localparam int DEF_FRAC    = 8;
    localparam int DEF_SAT_TH  = 250;
    localparam int DEF_DARK_TH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_R = 2'd1,
        ST_DIV_B = 2'd2,
        ST_DONE  = 2'd3
    } awb_state_t;

endpackage

// File: rtl/isp_awb_gain_m_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle, NUM_W cycles per divide.
// A start pulse while busy abandons the current divide and restarts with the new operands.
module isp_awb_gain_m_seq_div #(
    parameter int NUM_W = 40,
    parameter int DEN_W = 32
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot,
    output logic             div0
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] num_sh;
    logic [DEN_W-1:0] den_r;
    logic [DEN_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [DEN_W:0]   trial;
    logic             fits;

    // Remainder stays below the divisor, so one extra bit holds the shifted trial value.
    always_comb begin
        trial = {rem, num_sh[NUM_W-1]};
        fits  = (trial >= {1'b0, den_r});
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            num_sh <= '0;
            den_r  <= '0;
            rem    <= '0;
            quot   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else if (start) begin
            num_sh <= num;
            den_r  <= den;
            rem    <= '0;
            quot   <= '0;
            cnt    <= CNT_W'(NUM_W);
            busy   <= 1'b1;
            done   <= 1'b0;
            div0   <= (den == '0);
        end else if (busy) begin
            num_sh <= num_sh << 1;
            rem    <= fits ? DEN_W'(trial - {1'b0, den_r}) : trial[DEN_W-1:0];
            quot   <= {quot[NUM_W-2:0], fits};
            cnt    <= cnt - CNT_W'(1);
            done   <= (cnt == CNT_W'(1));
            busy   <= (cnt != CNT_W'(1));
        end else begin
            done   <= 1'b0;
        end
    end

endmodule

// File: rtl/isp_awb_gain_m.sv
// Gray-world auto white balance: per-frame channel sums, R/B gains against G computed
// in vertical blanking on one shared divider, and a 2-stage saturating gain pipeline.
module isp_awb_gain_m
    import isp_awb_gain_m_pkg::*;
#(
    parameter int BITS    = DEF_BITS,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int GAIN_W  = DEF_GAIN_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int SAT_TH  = DEF_SAT_TH,
    parameter int DARK_TH = DEF_DARK_TH
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              awb_en,
    input  logic              in_href,
    input  logic              in_vsync,
    input  logic              in_de,
    input  logic [BITS-1:0]   in_r,
    input  logic [BITS-1:0]   in_g,
    input  logic [BITS-1:0]   in_b,
    output logic              out_href,
    output logic              out_vsync,
    output logic              out_de,
    output logic [BITS-1:0]   out_r,
    output logic [BITS-1:0]   out_g,
    output logic [BITS-1:0]   out_b,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              stat_done,
    output awb_state_t        fsm_state
);

    localparam int NUM_W  = ACC_W + FRAC;
    localparam int PROD_W = BITS + GAIN_W;
    localparam int SHR_W  = PROD_W - FRAC;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [BITS-1:0]   DARK     = BITS'(DARK_TH);
    localparam logic [BITS-1:0]   SAT      = BITS'(SAT_TH);

    function automatic logic [GAIN_W-1:0] quot_to_gain(input logic [NUM_W-1:0] q,
                                                       input logic zero_den);
        if (zero_den)
            return GAIN_ONE;
        else if (|q[NUM_W-1:GAIN_W])
            return GAIN_MAX;
        else
            return q[GAIN_W-1:0];
    endfunction

    function automatic logic [BITS-1:0] sat_pix(input logic [SHR_W-1:0] x);
        return (|x[SHR_W-1:BITS]) ? '1 : x[BITS-1:0];
    endfunction

    // ---------------- statistics ----------------
    logic             vsync_d;
    logic             vs_rise;
    logic             vs_fall;
    logic             stat_ok;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b;
    logic [ACC_W-1:0] snap_g, snap_b;

    assign vs_rise = in_vsync & ~vsync_d;
    assign vs_fall = ~in_vsync & vsync_d;
    assign stat_ok = in_href & in_de & ~in_vsync
                   & (in_r >= DARK) & (in_r < SAT)
                   & (in_g >= DARK) & (in_g < SAT)
                   & (in_b >= DARK) & (in_b < SAT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            acc_r   <= '0;
            acc_g   <= '0;
            acc_b   <= '0;
            snap_g  <= '0;
            snap_b  <= '0;
        end else begin
            vsync_d <= in_vsync;
            if (vs_rise) begin
                snap_g <= acc_g;
                snap_b <= acc_b;
                acc_r  <= '0;
                acc_g  <= '0;
                acc_b  <= '0;
            end else if (stat_ok) begin
                acc_r <= acc_r + ACC_W'(in_r);
                acc_g <= acc_g + ACC_W'(in_g);
                acc_b <= acc_b + ACC_W'(in_b);
            end
        end
    end

    // ---------------- divider sharing and FSM ----------------
    awb_state_t       state, state_nx;
    logic             div_start;
    logic [NUM_W-1:0] div_num;
    logic [ACC_W-1:0] div_den;
    logic             div_busy, div_done, div_div0;
    logic [NUM_W-1:0] div_quot;

    // R divide takes the live sums on the frame-end cycle; B divide uses the snapshot.
    always_comb begin
        div_start = 1'b0;
        div_num   = {snap_g, {FRAC{1'b0}}};
        div_den   = snap_b;
        if (vs_rise) begin
            div_start = 1'b1;
            div_num   = {acc_g, {FRAC{1'b0}}};
            div_den   = acc_r;
        end else if (state == ST_DIV_R && div_done) begin
            div_start = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (vs_rise) begin
            state_nx = ST_DIV_R;
        end else begin
            case (state)
                ST_DIV_R: if (div_done) state_nx = ST_DIV_B;
                ST_DIV_B: if (div_done) state_nx = ST_DONE;
                ST_DONE:  state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    assign fsm_state = state;
    assign stat_done = (state == ST_DONE) && !vs_rise;

    isp_awb_gain_m_seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (ACC_W)
    ) u_div (
        .pclk  (pclk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot),
        .div0  (div_div0)
    );

    // ---------------- gain results and frame-boundary commit ----------------
    logic [GAIN_W-1:0] calc_r, calc_b;
    logic              pending;
    logic              commit;

    assign commit = vs_fall && pending && (state == ST_IDLE) && !div_busy;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            calc_r  <= GAIN_ONE;
            calc_b  <= GAIN_ONE;
            pending <= 1'b0;
            gain_r  <= GAIN_ONE;
            gain_b  <= GAIN_ONE;
        end else begin
            if (!vs_rise && div_done && state == ST_DIV_R)
                calc_r <= quot_to_gain(div_quot, div_div0);
            if (!vs_rise && div_done && state == ST_DIV_B)
                calc_b <= quot_to_gain(div_quot, div_div0);
            if (stat_done)
                pending <= 1'b1;
            else if (commit)
                pending <= 1'b0;
            if (commit) begin
                gain_r <= awb_en ? calc_r : GAIN_ONE;
                gain_b <= awb_en ? calc_b : GAIN_ONE;
            end
        end
    end

    // ---------------- 2-stage gain pipeline ----------------
    logic [SHR_W-1:0] prod_r_s1, prod_b_s1;
    logic [BITS-1:0]  g_s1;
    logic [2:0]       sync_s1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_s1 <= '0;
            prod_b_s1 <= '0;
            g_s1      <= '0;
            sync_s1   <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else begin
            prod_r_s1 <= SHR_W'((PROD_W'(in_r) * PROD_W'(gain_r)) >> FRAC);
            prod_b_s1 <= SHR_W'((PROD_W'(in_b) * PROD_W'(gain_b)) >> FRAC);
            g_s1      <= in_g;
            sync_s1   <= {in_href, in_vsync, in_de};
            out_href  <= sync_s1[2];
            out_vsync <= sync_s1[1];
            out_de    <= sync_s1[0];
            out_r     <= sync_s1[2] ? sat_pix(prod_r_s1) : '0;
            out_g     <= sync_s1[2] ? g_s1 : '0;
            out_b     <= sync_s1[2] ? sat_pix(prod_b_s1) : '0;
        end
    end

endmodule

// File: tb/tb_isp_awb_gain_m.sv
// Bench for isp_awb_gain_m: frame-level driver, gray-world reference model and
// an expected-pixel queue checked against the 2-cycle output stream.
module tb_isp_awb_gain_m;
    import isp_awb_gain_m_pkg::*;

    localparam int LINES      = 4;
    localparam int PX         = 8;
    localparam int LONG_BLANK = 100;
    localparam int SHORT_BLANK = 20;
    localparam int MIN_BLANK  = 90;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       awb_en = 1'b1;
    logic       in_href = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic       out_href, out_vsync, out_de;
    logic [7:0] out_r, out_g, out_b;
    logic [9:0] gain_r, gain_b;
    logic       stat_done;
    awb_state_t fsm_state;

    always #5 pclk = ~pclk;

    isp_awb_gain_m dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .awb_en    (awb_en),
        .in_href   (in_href),
        .in_vsync  (in_vsync),
        .in_de     (in_de),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_href  (out_href),
        .out_vsync (out_vsync),
        .out_de    (out_de),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .gain_r    (gain_r),
        .gain_b    (gain_b),
        .stat_done (stat_done),
        .fsm_state (fsm_state)
    );

    int          assert_cnt = 0;
    int          fail_cnt = 0;
    logic [23:0] exp_q[$];
    int          done_cnt = 0;
    bit          chk_en = 1'b0;
    logic [2:0]  h1, h2;
    int          m_sum_r = 0, m_sum_g = 0, m_sum_b = 0;
    int          m_gain_r = 256, m_gain_b = 256;
    int          m_calc_r = 256, m_calc_b = 256;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic int model_gain(input int sg, input int sn);
        longint q;
        if (sn == 0) return 256;
        q = (longint'(sg) * 256) / sn;
        return (q > 1023) ? 1023 : int'(q);
    endfunction

    // ---------------- clock/reset-side history and monitor ----------------
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= {in_href, in_vsync, in_de};
            h2 <= h1;
        end
    end

    always @(negedge pclk) begin
        if (rst_n && chk_en) begin
            check("sync_delay", {out_href, out_vsync, out_de}, h2);
            if (out_href) begin
                if (exp_q.size() == 0)
                    check("queue_depth", exp_q.size(), 1);
                else
                    check("pixel", {out_r, out_g, out_b}, exp_q.pop_front());
            end else begin
                check("blank_pixel", {out_r, out_g, out_b}, 0);
            end
            if (stat_done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pixel(input int r, input int g, input int b);
        in_href  = 1'b1;
        in_de    = 1'b1;
        in_vsync = 1'b0;
        in_r     = 8'(r);
        in_g     = 8'(g);
        in_b     = 8'(b);
        exp_q.push_back({8'(sat8((r * m_gain_r) >> 8)), 8'(g), 8'(sat8((b * m_gain_b) >> 8))});
        if (r >= 8 && r < 250 && g >= 8 && g < 250 && b >= 8 && b < 250) begin
            m_sum_r += r;
            m_sum_g += g;
            m_sum_b += b;
        end
        tick();
    endtask

    task automatic idle(input int n, input bit vs);
        for (int i = 0; i < n; i++) begin
            in_href  = 1'b0;
            in_de    = 1'b0;
            in_vsync = vs;
            in_r     = 8'($urandom_range(0, 255));
            in_g     = 8'($urandom_range(0, 255));
            in_b     = 8'($urandom_range(0, 255));
            tick();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"}, {out_href, out_vsync, out_de, out_r, out_g, out_b}, 0);
        check({tag, "_gain_r"}, gain_r, 256);
        check({tag, "_gain_b"}, gain_b, 256);
        check({tag, "_stat_done"}, stat_done, 0);
        check({tag, "_fsm"}, fsm_state, ST_IDLE);
    endtask

    // r alternates r0/r1 across a line; rst_at > 0 pulses reset that many cycles into blanking.
    task automatic run_frame(input int r0, input int r1, input int g0, input int b0,
                             input bit rnd, input int blank, input int rst_at);
        for (int l = 0; l < LINES; l++) begin
            for (int p = 0; p < PX; p++) begin
                if (rnd)
                    pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                else
                    pixel((p % 2 == 1) ? r1 : r0, g0, b0);
            end
            idle(2, 1'b0);
        end
        check("stray_done", done_cnt, 0);
        done_cnt = 0;
        m_calc_r = model_gain(m_sum_g, m_sum_r);
        m_calc_b = model_gain(m_sum_g, m_sum_b);
        m_sum_r = 0;
        m_sum_g = 0;
        m_sum_b = 0;
        if (rst_at == 0) begin
            idle(blank, 1'b1);
            idle(3, 1'b0);
            if (blank >= MIN_BLANK) begin
                m_gain_r = awb_en ? m_calc_r : 256;
                m_gain_b = awb_en ? m_calc_b : 256;
            end
            check("stat_done_cnt", done_cnt, (blank >= MIN_BLANK) ? 1 : 0);
        end else begin
            idle(rst_at, 1'b1);
            check("fsm_dividing", fsm_state, ST_DIV_R);
            rst_n    = 1'b0;
            in_vsync = 1'b0;
            #20;
            rst_n    = 1'b1;
            m_gain_r = 256;
            m_gain_b = 256;
            check_reset_state("mid_rst");
            idle(blank, 1'b0);
            check("stat_done_after_rst", done_cnt, 0);
        end
        done_cnt = 0;
        check("gain_r", gain_r, m_gain_r);
        check("gain_b", gain_b, m_gain_b);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check_reset_state("reset");

        run_frame(100, 100, 100, 100, 1'b0, LONG_BLANK, 0);
        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 0);
        check("gain_r_x2", gain_r, 512);
        check("gain_b_half", gain_b, 128);
        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 0);
        run_frame(40, 40, 200, 200, 1'b0, LONG_BLANK, 0);
        check("gain_r_clamp", gain_r, 1023);
        run_frame(40, 100, 200, 200, 1'b0, LONG_BLANK, 0);
        run_frame(0, 0, 0, 0, 1'b1, LONG_BLANK, 0);
        run_frame(0, 0, 100, 100, 1'b0, LONG_BLANK, 0);
        check("gain_r_dark", gain_r, 256);
        run_frame(0, 0, 0, 0, 1'b1, LONG_BLANK, 0);
        run_frame(250, 255, 252, 251, 1'b0, LONG_BLANK, 0);
        check("gain_b_sat", gain_b, 256);

        run_frame(50, 50, 100, 200, 1'b0, SHORT_BLANK, 0);
        run_frame(100, 100, 100, 50, 1'b0, LONG_BLANK, 0);
        check("gain_b_second_frame", gain_b, 512);

        awb_en = 1'b0;
        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 0);
        awb_en = 1'b1;

        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 15);
        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 0);
        run_frame(50, 50, 100, 200, 1'b0, LONG_BLANK, 0);

        idle(5, 1'b0);
        check("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
